// File: rtl/collision_monitor_pkg.sv
// Shared definitions for the collision monitor: FSM state encodings and
// the death-cause codes reported on the `cause` output.
package collision_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAFE  = 2'd1,
        ST_ARMED = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_FLOOR = 2'd1,
        CAUSE_CEIL  = 2'd2,
        CAUSE_PIPE  = 2'd3
    } cause_t;

endpackage

// File: rtl/collision_monitor_pipe_hit_check.sv
// Combinational overlap test between the bird and one pipe channel.
// Ports:
//   height  - bird top row
//   pipe_x  - pipe left column
//   gap_top - top row of the pipe's open gap
//   hit     - bird overlaps the pipe columns and is not fully inside the gap
module collision_monitor_pipe_hit_check #(
    parameter int H_W    = 9,
    parameter int X_W    = 10,
    parameter int BIRD_X = 100,
    parameter int BIRD_W = 16,
    parameter int BIRD_H = 16,
    parameter int PIPE_W = 40,
    parameter int GAP_H  = 120
) (
    input  logic [H_W-1:0] height,
    input  logic [X_W-1:0] pipe_x,
    input  logic [H_W-1:0] gap_top,
    output logic           hit
);

    // Two spare bits so the sums below can never wrap.
    localparam int HE = H_W + 2;
    localparam int XE = X_W + 2;

    logic [HE-1:0] bird_top;
    logic [HE-1:0] bird_bot;
    logic [HE-1:0] gap_hi;
    logic [HE-1:0] gap_lo;
    logic [XE-1:0] px;
    logic          x_overlap;

    assign bird_top  = HE'(height);
    assign bird_bot  = HE'(height) + HE'(BIRD_H);
    assign gap_hi    = HE'(gap_top);
    assign gap_lo    = HE'(gap_top) + HE'(GAP_H);
    assign px        = XE'(pipe_x);
    assign x_overlap = (px < XE'(BIRD_X + BIRD_W)) && ((px + XE'(PIPE_W)) > XE'(BIRD_X));
    assign hit       = x_overlap && ((bird_top < gap_hi) || (bird_bot > gap_lo));

endmodule

// File: rtl/collision_monitor.sv
// Per-frame bird death decision against floor, ceiling and N_PIPES pipes.
// A run starts with a spawn-protection window of SAFE_FRAMES ticks, then is
// armed; floor contact kills at once, ceiling/pipe contact must persist for
// GRACE_FRAMES consecutive ticks. Cause and offending pipes latch at death.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   frame_tick           - once-per-frame strobe; inputs are only evaluated here
//   start                - begin a run (from IDLE) or restart (from DEAD)
//   height               - bird top row
//   pipe_x / gap_top     - packed per-channel pipe column / gap top row
//   is_dead, alive       - registered status flags
//   cause, hit_pipe      - latched death cause and violating channels
//   state                - IDLE/SAFE/ARMED/DEAD
module collision_monitor
    import collision_monitor_pkg::*;
#(
    parameter int H_W          = 9,
    parameter int X_W          = 10,
    parameter int N_PIPES      = 2,
    parameter int FLOOR_Y      = 440,
    parameter int CEIL_Y       = 8,
    parameter int BIRD_X       = 100,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int PIPE_W       = 40,
    parameter int GAP_H        = 120,
    parameter int GRACE_FRAMES = 2,
    parameter int SAFE_FRAMES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic [H_W-1:0]         height,
    input  logic [N_PIPES*X_W-1:0] pipe_x,
    input  logic [N_PIPES*H_W-1:0] gap_top,
    output logic                   is_dead,
    output logic                   alive,
    output logic [1:0]             cause,
    output logic [N_PIPES-1:0]     hit_pipe,
    output logic [1:0]             state
);

    localparam int HE       = H_W + 2;
    localparam int SAFE_CW  = (SAFE_FRAMES > 0) ? $clog2(SAFE_FRAMES + 1) : 1;
    localparam int GRACE_CW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    state_t                state_q, state_d;
    logic [SAFE_CW-1:0]    safe_q, safe_d;
    logic [GRACE_CW-1:0]   grace_q, grace_d, grace_inc;
    cause_t                cause_q, cause_d;
    logic [N_PIPES-1:0]    hit_q, hit_d;
    logic [N_PIPES-1:0]    pipe_v;
    logic [HE-1:0]         h_ext;
    logic                  floor_v;
    logic                  ceil_v;

    for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
        collision_monitor_pipe_hit_check #(
            .H_W    (H_W),
            .X_W    (X_W),
            .BIRD_X (BIRD_X),
            .BIRD_W (BIRD_W),
            .BIRD_H (BIRD_H),
            .PIPE_W (PIPE_W),
            .GAP_H  (GAP_H)
        ) u_chk (
            .height  (height),
            .pipe_x  (pipe_x[i*X_W +: X_W]),
            .gap_top (gap_top[i*H_W +: H_W]),
            .hit     (pipe_v[i])
        );
    end

    assign h_ext     = HE'(height);
    assign floor_v   = (h_ext + HE'(BIRD_H)) > HE'(FLOOR_Y);
    assign ceil_v    = h_ext < HE'(CEIL_Y);
    assign grace_inc = grace_q + GRACE_CW'(1);

    always_comb begin
        state_d = state_q;
        safe_d  = safe_q;
        grace_d = grace_q;
        cause_d = cause_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SAFE;
                    safe_d  = SAFE_CW'(SAFE_FRAMES);
                    grace_d = '0;
                end
            end
            ST_SAFE: begin
                if (frame_tick) begin
                    safe_d = safe_q - SAFE_CW'(1);
                    if (safe_q == SAFE_CW'(1)) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (frame_tick) begin
                    if (floor_v) begin
                        state_d = ST_DEAD;
                        cause_d = CAUSE_FLOOR;
                        hit_d   = pipe_v;
                    end else if (ceil_v || (|pipe_v)) begin
                        grace_d = grace_inc;
                        if (grace_inc >= GRACE_CW'(GRACE_FRAMES)) begin
                            state_d = ST_DEAD;
                            cause_d = ceil_v ? CAUSE_CEIL : CAUSE_PIPE;
                            hit_d   = pipe_v;
                        end
                    end else begin
                        // A clean frame breaks the violation streak.
                        grace_d = '0;
                    end
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_d = ST_SAFE;
                    safe_d  = SAFE_CW'(SAFE_FRAMES);
                    grace_d = '0;
                    cause_d = CAUSE_NONE;
                    hit_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            safe_q   <= '0;
            grace_q  <= '0;
            cause_q  <= CAUSE_NONE;
            hit_q    <= '0;
            is_dead  <= 1'b0;
            alive    <= 1'b0;
        end else begin
            state_q  <= state_d;
            safe_q   <= safe_d;
            grace_q  <= grace_d;
            cause_q  <= cause_d;
            hit_q    <= hit_d;
            is_dead  <= (state_d == ST_DEAD);
            alive    <= (state_d == ST_SAFE) || (state_d == ST_ARMED);
        end
    end

    assign state    = state_q;
    assign cause    = cause_q;
    assign hit_pipe = hit_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Bench for collision_monitor: directed scenarios with literal expectations,
// then randomized frames, all compared every cycle against a run-level model.
module tb_collision_monitor;

    localparam int H_W     = 9;
    localparam int X_W     = 10;
    localparam int NP      = 2;
    localparam int FLOOR_Y = 440;
    localparam int CEIL_Y  = 8;
    localparam int BIRD_X  = 100;
    localparam int BIRD_W  = 16;
    localparam int BIRD_H  = 16;
    localparam int PIPE_W  = 40;
    localparam int GAP_H   = 120;
    localparam int GRACE   = 2;
    localparam int SAFE    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                frame_tick;
    logic                start;
    logic [H_W-1:0]      height;
    logic [NP*X_W-1:0]   pipe_x;
    logic [NP*H_W-1:0]   gap_top;
    logic                is_dead;
    logic                alive;
    logic [1:0]          cause;
    logic [NP-1:0]       hit_pipe;
    logic [1:0]          state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    collision_monitor #(
        .H_W(H_W), .X_W(X_W), .N_PIPES(NP), .FLOOR_Y(FLOOR_Y), .CEIL_Y(CEIL_Y),
        .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H), .PIPE_W(PIPE_W),
        .GAP_H(GAP_H), .GRACE_FRAMES(GRACE), .SAFE_FRAMES(SAFE)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .height(height), .pipe_x(pipe_x), .gap_top(gap_top),
        .is_dead(is_dead), .alive(alive), .cause(cause), .hit_pipe(hit_pipe),
        .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- run-level reference model ----------------
    bit            m_run;      // a run has been started since reset
    bit            m_dead;
    int            m_ticks;    // frame ticks seen since the run started (saturates at SAFE)
    int            m_streak;   // consecutive ceiling/pipe-violating armed frames
    int            m_cause;
    logic [NP-1:0] m_hit;

    function automatic bit pipe_hit(input int px, input int gt, input int h);
        return (px < BIRD_X + BIRD_W) && (px + PIPE_W > BIRD_X) &&
               (h < gt || h + BIRD_H > gt + GAP_H);
    endfunction

    function automatic int exp_state();
        if (!m_run)          return 0;
        if (m_dead)          return 3;
        if (m_ticks < SAFE)  return 1;
        return 2;
    endfunction

    always @(posedge clk) begin : model
        int            h;
        logic [NP-1:0] pv;
        bit            fv;
        bit            cv;
        h = int'(height);
        if (reset) begin
            m_run = 0; m_dead = 0; m_ticks = 0; m_streak = 0; m_cause = 0; m_hit = '0;
        end else if (start && (!m_run || m_dead)) begin
            m_run = 1; m_dead = 0; m_ticks = 0; m_streak = 0; m_cause = 0; m_hit = '0;
        end else if (frame_tick && m_run && !m_dead) begin
            if (m_ticks < SAFE) begin
                m_ticks++;
            end else begin
                for (int i = 0; i < NP; i++)
                    pv[i] = pipe_hit(int'(pipe_x[i*X_W +: X_W]), int'(gap_top[i*H_W +: H_W]), h);
                fv = (h + BIRD_H > FLOOR_Y);
                cv = (h < CEIL_Y);
                if (fv) begin
                    m_dead = 1; m_cause = 1; m_hit = pv;
                end else if (cv || pv != '0) begin
                    m_streak++;
                    if (m_streak >= GRACE) begin
                        m_dead = 1; m_cause = cv ? 2 : 3; m_hit = pv;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("state", state, exp_state());
        check("is_dead", is_dead, (m_run && m_dead) ? 1 : 0);
        check("alive", alive, (m_run && !m_dead) ? 1 : 0);
        check("cause", cause, m_cause);
        check("hit_pipe", hit_pipe, m_hit);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit st, input bit tk);
        start      = st;
        frame_tick = tk;
        @(posedge clk);
        #2;
        start      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        height     = 9'd250;
        pipe_x     = {10'd639, 10'd639};
        gap_top    = {9'd200, 9'd200};
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", state, 0);
        check("rst_dead", is_dead, 0);
        check("rst_alive", alive, 0);
        check("rst_cause", cause, 0);
        check("rst_hit", hit_pipe, 0);
        reset = 1'b0;

        // spawn window then armed flight
        cyc(1'b1, 1'b0);
        check("t1_safe", state, 1);
        ticks(3);
        check("t1_still_safe", state, 1);
        ticks(1);
        check("t1_armed", state, 2);
        ticks(10);
        check("t1_alive", alive, 1);
        check("t1_cause", cause, 0);

        // floor: 425+16 > 440, immediate
        height = 9'd425;
        ticks(1);
        check("t2_dead", is_dead, 1);
        check("t2_cause", cause, 1);
        check("t2_state", state, 3);

        // ceiling with grace, streak broken by a clean frame
        cyc(1'b1, 1'b0);
        height = 9'd100;
        ticks(4);
        height = 9'd5;
        ticks(1);
        check("t3_grace1", alive, 1);
        height = 9'd100;
        ticks(1);
        height = 9'd5;
        ticks(1);
        check("t3_restreak", alive, 1);
        ticks(1);
        check("t3_dead", is_dead, 1);
        check("t3_cause", cause, 2);
        check("t3_hit", hit_pipe, 0);

        // pipe channel 1
        cyc(1'b1, 1'b0);
        height = 9'd250;
        ticks(4);
        pipe_x[X_W +: X_W]   = 10'd90;
        gap_top[H_W +: H_W]  = 9'd200;
        ticks(1);
        check("t4_in_gap", alive, 1);
        height = 9'd150;
        ticks(2);
        check("t4_cause", cause, 3);
        check("t4_hit", hit_pipe, 2'b10);

        // no checks during spawn protection
        pipe_x = {10'd639, 10'd639};
        cyc(1'b1, 1'b0);
        height = 9'd460;
        ticks(3);
        check("t5_safe", state, 1);
        ticks(1);
        check("t5_armed", state, 2);
        check("t5_alive", alive, 1);
        ticks(1);
        check("t5_floor", cause, 1);

        // restart clears, reset mid-streak, start+tick in IDLE
        cyc(1'b1, 1'b0);
        check("t6_restart", state, 1);
        check("t6_cause", cause, 0);
        height = 9'd100;
        ticks(4);
        height = 9'd5;
        ticks(1);
        reset = 1'b1;
        cyc(1'b0, 1'b1);
        reset = 1'b0;
        check("t6_rst_state", state, 0);
        check("t6_rst_alive", alive, 0);
        height = 9'd100;
        cyc(1'b1, 1'b1);
        ticks(3);
        check("t6_tick_ignored", state, 1);
        ticks(1);
        check("t6_armed", state, 2);

        // randomized frames
        for (int n = 0; n < 4000; n++) begin
            int r;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 2)      height = H_W'($urandom_range(0, 12));
                else if (r < 4) height = H_W'($urandom_range(415, 511));
                else            height = H_W'($urandom_range(100, 330));
            end
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    pipe_x[i*X_W +: X_W]  = ($urandom_range(0, 1) == 1) ?
                        X_W'($urandom_range(40, 140)) : X_W'($urandom_range(0, 1023));
                    gap_top[i*H_W +: H_W] = H_W'($urandom_range(0, 400));
                end
            end
            cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0));
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
